// File: rtl/uart_rx_frmr.sv
// 8N1 LSB-first UART receiver. The RX pin is synchronized, and each bit is timed
// at its centre by a baud down-counter. Optional stop-bit check: UART_RX_FRAMING_CHK_EN.
module uart_rx_frmr #(
    parameter int unsigned BAUD_CNT = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);

    localparam logic [11:0] BAUD_FULL = 12'(BAUD_CNT);
    localparam logic [11:0] BAUD_HALF = 12'(BAUD_CNT / 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        rx_sync1_q, rx_sync2_q, rx_prev_q;
    logic        rx_fall_s;
    logic        baud_term_s;
    logic [11:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rdy_q, rdy_d;
`ifdef UART_RX_FRAMING_CHK_EN
    logic        frm_err_q, frm_err_d;
`endif

    assign rx_fall_s   = rx_prev_q & ~rx_sync2_q;
    assign baud_term_s = (baud_cnt_q == 12'd1);

    // Synchronizer plus edge-detect flop; all flops idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            rx_sync1_q <= RX;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; falling edges outside IDLE never restart a frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_fall_s) state_d = ST_START;
                else           state_d = ST_IDLE;
            end
            ST_START: begin
                if (baud_term_s) begin
                    if (rx_sync2_q) state_d = ST_IDLE;
                    else            state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_term_s && (bit_cnt_q == 3'd7)) state_d = ST_STOP;
                else                                    state_d = ST_DATA;
            end
            ST_STOP: begin
                if (baud_term_s) state_d = ST_IDLE;
                else             state_d = ST_STOP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output / datapath next-state logic; a stop-sample set overrides clr_rdy.
    always_comb begin
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        if (clr_rdy) rdy_d = 1'b0;
        else         rdy_d = rdy_q;
`ifdef UART_RX_FRAMING_CHK_EN
        if (clr_rdy) frm_err_d = 1'b0;
        else         frm_err_d = frm_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_fall_s) begin
                    baud_cnt_d = BAUD_HALF;
                    bit_cnt_d  = 3'd0;
                    rdy_d      = 1'b0;
                end else begin
                    baud_cnt_d = baud_cnt_q;
                end
            end
            ST_START: begin
                if (baud_term_s) begin
                    if (rx_sync2_q) baud_cnt_d = 12'd0;
                    else            baud_cnt_d = BAUD_FULL;
                end else begin
                    baud_cnt_d = baud_cnt_q - 12'd1;
                end
            end
            ST_DATA: begin
                if (baud_term_s) begin
                    shift_d    = {rx_sync2_q, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    baud_cnt_d = BAUD_FULL;
                end else begin
                    baud_cnt_d = baud_cnt_q - 12'd1;
                end
            end
            ST_STOP: begin
                if (baud_term_s) begin
                    baud_cnt_d = 12'd0;
`ifdef UART_RX_FRAMING_CHK_EN
                    if (rx_sync2_q) begin
                        rx_data_d = shift_q;
                        rdy_d     = 1'b1;
                        frm_err_d = 1'b0;
                    end else begin
                        frm_err_d = 1'b1;
                    end
`else
                    rx_data_d = shift_q;
                    rdy_d     = 1'b1;
`endif
                end else begin
                    baud_cnt_d = baud_cnt_q - 12'd1;
                end
            end
            default: begin
                baud_cnt_d = 12'd0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_q <= 12'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rdy_q      <= 1'b0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rdy_q      <= rdy_d;
        end
    end

`ifdef UART_RX_FRAMING_CHK_EN
    // Framing-error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_err_q <= 1'b0;
        end else begin
            frm_err_q <= frm_err_d;
        end
    end

    assign frm_err = frm_err_q;
`else
    assign frm_err = 1'b0;
`endif

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;

endmodule

// File: tb/tb_uart_rx_frmr.sv
// Directed bench for uart_rx_frmr with BAUD_CNT = 16; each frame spans 160 cycles.
module tb_uart_rx_frmr;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;

    int n_pass  = 0;
    int n_total = 0;

    logic       rec_rdy  [0:159];
    logic [7:0] rec_data [0:159];
    logic       rec_err  [0:159];

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         clr_at;
        logic [7:0] exp_data;
        logic       exp_rdy;
        logic       exp_err;
    } vec_t;

    vec_t vecs [7];

    uart_rx_frmr #(.BAUD_CNT(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (rx),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after a rising edge; cycle c starts there. Records outputs mid-cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int clr_at);
        logic [7:0] bb;
        bb = b;
        for (int c = 0; c < 160; c++) begin
            if (c < 16)       rx = 1'b0;
            else if (c < 144) rx = bb[c / 16 - 1];
            else              rx = stop;
            clr_rdy = (c == clr_at);
            @(negedge clk);
            rec_rdy[c]  = rdy;
            rec_data[c] = rx_data;
            rec_err[c]  = frm_err;
            @(posedge clk);
            #1;
        end
        rx      = 1'b1;
        clr_rdy = 1'b0;
    endtask

    initial begin
`ifdef UART_RX_FRAMING_CHK_EN
        vecs[0] = '{8'h00, 1'b1, -1,  8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 154, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, -1,  8'hFF, 1'b0, 1'b1};
        vecs[3] = '{8'h55, 1'b1, -1,  8'h55, 1'b1, 1'b0};
        vecs[4] = '{8'hAA, 1'b1, -1,  8'hAA, 1'b1, 1'b0};
        vecs[5] = '{8'h81, 1'b0, -1,  8'hAA, 1'b0, 1'b1};
        vecs[6] = '{8'h18, 1'b1, -1,  8'h18, 1'b1, 1'b0};
`else
        vecs[0] = '{8'h00, 1'b1, -1,  8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 154, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, -1,  8'h3C, 1'b1, 1'b0};
        vecs[3] = '{8'h55, 1'b1, -1,  8'h55, 1'b1, 1'b0};
        vecs[4] = '{8'hAA, 1'b1, -1,  8'hAA, 1'b1, 1'b0};
        vecs[5] = '{8'h81, 1'b0, -1,  8'h81, 1'b1, 1'b0};
        vecs[6] = '{8'h18, 1'b1, -1,  8'h18, 1'b1, 1'b0};
`endif

        rst_n   = 1'b0;
        rx      = 1'b1;
        clr_rdy = 1'b0;
        #23;
        check("reset_rdy", rdy, 1'b0);
        check("reset_data", rx_data, 8'h00);
        check("reset_err", frm_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);

        // Single frame 'g': exact stop-sample timing, then sticky rdy and clr.
        send_frame(8'h67, 1'b1, -1);
        check("g_rdy_t152", rec_rdy[154], 1'b0);
        check("g_rdy_t153", rec_rdy[155], 1'b1);
        check("g_data_t152", rec_data[154], 8'h00);
        check("g_data_t153", rec_data[155], 8'h67);
        idle(20);
        @(negedge clk);
        check("g_rdy_sticky", rdy, 1'b1);
        @(posedge clk);
        #1;
        clr_rdy = 1'b1;
        @(negedge clk);
        check("g_rdy_clr_cycle", rdy, 1'b1);
        @(posedge clk);
        #1;
        clr_rdy = 1'b0;
        @(negedge clk);
        check("g_rdy_after_clr", rdy, 1'b0);
        @(posedge clk);
        #1;

        // Back-to-back 'g' then 's' with no acknowledge.
        send_frame(8'h67, 1'b1, -1);
        check("b2b_first_rdy", rec_rdy[155], 1'b1);
        send_frame(8'h73, 1'b1, -1);
        check("b2b_rdy_before_edge", rec_rdy[2], 1'b1);
        check("b2b_rdy_drop", rec_rdy[3], 1'b0);
        check("b2b_old_data", rec_data[154], 8'h67);
        check("b2b_new_data", rec_data[155], 8'h73);
        check("b2b_new_rdy", rec_rdy[155], 1'b1);
        idle(20);

        // 4-clock glitch: false start.
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(30);
        @(negedge clk);
        check("glitch_rdy", rdy, 1'b0);
        check("glitch_data", rx_data, 8'h73);
        @(posedge clk);
        #1;

        // Table of frames, each followed by a short idle gap.
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].b, vecs[i].stop, vecs[i].clr_at);
            check($sformatf("vec%0d_data", i), rec_data[155], vecs[i].exp_data);
            check($sformatf("vec%0d_rdy", i), rec_rdy[155], vecs[i].exp_rdy);
            check($sformatf("vec%0d_err", i), rec_err[155], vecs[i].exp_err);
            idle(20);
        end

        // Bad stop bit followed by acknowledge.
        send_frame(8'h3C, 1'b0, -1);
        idle(10);
        @(negedge clk);
`ifdef UART_RX_FRAMING_CHK_EN
        check("badstop_err", frm_err, 1'b1);
        check("badstop_data", rx_data, 8'h18);
`else
        check("badstop_err", frm_err, 1'b0);
        check("badstop_data", rx_data, 8'h3C);
`endif
        @(posedge clk);
        #1;
        clr_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_rdy = 1'b0;
        @(negedge clk);
        check("clr_err", frm_err, 1'b0);
        check("clr_rdy_idle", rdy, 1'b0);
        @(posedge clk);
        #1;

        // Reset in the middle of DATA, then a clean frame.
        rx = 1'b0;
        idle(16);
        rx = 1'b1;
        idle(44);
        rst_n = 1'b0;
        #2;
        check("midrst_rdy", rdy, 1'b0);
        check("midrst_data", rx_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        rx    = 1'b1;
        idle(30);
        send_frame(8'hA5, 1'b1, -1);
        check("post_rst_data", rec_data[155], 8'hA5);
        check("post_rst_rdy", rec_rdy[155], 1'b1);
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
